matrix_2x2_inverse_seq: RTL and testbench

Sequential 2x2 signed matrix inverter, the inverse counterpart of the matrix multiplier/determinant block in the same Qsys accelerator.
- Computes det(A) and the adjugate, then divides each adjugate element by det using one shared restoring divider.
- Produces signed fixed-point outputs with FRAC fractional bits.
- Sits behind the same start/done control wrapper as the other matrix blocks.

---
 rtl/matrix_2x2_inverse_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_matrix_2x2_inverse_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_2x2_inverse_seq.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_2x2_inverse_seq
//  Brief    : Sequential 2x2 signed matrix inverter. Computes det(A) and the
//             adjugate, then divides each adjugate element by det using one
//             shared restoring divider.
//  Revision : 1.0  initial release
// ============================================================================
module matrix_2x2_inverse_seq #(
    parameter int WIDTH = 7,
    parameter int FRAC  = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic [4*WIDTH-1:0]              matA,
    output logic                            busy,
    output logic                            done,
    output logic                            singular,
    output logic [2*WIDTH:0]                determinant,
    output logic [4*(WIDTH+FRAC+1)-1:0]     inv_mat
);

    localparam int OW   = WIDTH + FRAC + 1;
    localparam int DW   = WIDTH + FRAC;
    localparam int DETW = 2*WIDTH + 1;
    localparam int CW   = $clog2(DW);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DET  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]               state_q, state_d;
    logic signed [WIDTH-1:0]  a_q      [4];
    logic signed [WIDTH-1:0]  a_d      [4];
    logic signed [WIDTH:0]    adj_q    [4];
    logic signed [WIDTH:0]    adj_d    [4];
    logic signed [DETW-1:0]   det_q, det_d;
    logic [1:0]               k_q, k_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [DETW-1:0]          rem_q, rem_d;
    logic [DW-1:0]            quo_q, quo_d;
    logic signed [OW-1:0]     shadow_q [4];
    logic signed [OW-1:0]     shadow_d [4];
    logic                     singular_q, singular_d;
    logic signed [DETW-1:0]   determinant_q, determinant_d;
    logic [4*OW-1:0]          inv_q, inv_d;

    logic signed [WIDTH-1:0]  w_mat    [4];
    logic signed [WIDTH:0]    w_adj    [4];
    logic signed [DETW-1:0]   w_det;
    logic signed [DETW:0]     w_det_ext;
    logic [DETW:0]            w_det_abs;
    logic [DETW:0]            w_rem_shift;
    logic                     w_ge;
    logic [OW-1:0]            w_q_mag;
    logic                     w_neg;
    logic signed [OW-1:0]     w_fix;
    logic [1:0]               w_k_next;
    logic                     w_div_last;

    // a00 sits at the MSBs of matA
    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
        assign w_mat[gi] = matA[(4-gi)*WIDTH-1 -: WIDTH];
    end

    // Magnitude is one bit wider so that -2^(WIDTH-1) survives negation.
    function automatic logic [DW-1:0] dividend_of(input logic signed [WIDTH:0] v);
        logic [WIDTH:0] mag;
        mag = v[WIDTH] ? -v : v;
        return DW'({mag, {FRAC{1'b0}}});
    endfunction

    assign w_det = DETW'(a_q[0]) * DETW'(a_q[3]) - DETW'(a_q[1]) * DETW'(a_q[2]);

    always_comb begin
        w_adj[0] =   (WIDTH+1)'(a_q[3]);
        w_adj[1] = -((WIDTH+1)'(a_q[1]));
        w_adj[2] = -((WIDTH+1)'(a_q[2]));
        w_adj[3] =   (WIDTH+1)'(a_q[0]);
    end

    assign w_det_ext   = (DETW+1)'(det_q);
    assign w_det_abs   = w_det_ext[DETW] ? -w_det_ext : w_det_ext;
    assign w_rem_shift = {rem_q, quo_q[DW-1]};
    assign w_ge        = (w_rem_shift >= w_det_abs);
    assign w_q_mag     = {1'b0, quo_q};
    assign w_neg       = adj_q[k_q][WIDTH] ^ det_q[DETW-1];
    assign w_fix       = w_neg ? -w_q_mag : w_q_mag;
    assign w_k_next    = k_q + 2'd1;
    assign w_div_last  = (cnt_q == CW'(DW-1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_DET;
            S_DET:  state_d = (w_det == '0) ? S_DONE : S_DIV;
            S_DIV:  if (w_div_last) state_d = S_FIX;
            S_FIX:  state_d = (k_q == 2'd3) ? S_DONE : S_DIV;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_DET, S_DIV, S_FIX: busy = 1'b1;
            S_DONE:              done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_d[i]      = a_q[i];
            adj_d[i]    = adj_q[i];
            shadow_d[i] = shadow_q[i];
        end
        det_d         = det_q;
        k_d           = k_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        singular_d    = singular_q;
        determinant_d = determinant_q;
        inv_d         = inv_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int i = 0; i < 4; i++) a_d[i] = w_mat[i];
                end
            end
            S_DET: begin
                det_d = w_det;
                for (int i = 0; i < 4; i++) adj_d[i] = w_adj[i];
                k_d   = 2'd0;
                cnt_d = '0;
                rem_d = '0;
                quo_d = dividend_of(w_adj[0]);
                if (w_det == '0) begin
                    singular_d    = 1'b1;
                    determinant_d = '0;
                    inv_d         = '0;
                end
            end
            S_DIV: begin
                // Dividend bits shift out of quo_q while quotient bits shift in.
                rem_d = w_ge ? DETW'(w_rem_shift - w_det_abs) : DETW'(w_rem_shift);
                quo_d = {quo_q[DW-2:0], w_ge};
                cnt_d = cnt_q + CW'(1);
            end
            S_FIX: begin
                shadow_d[k_q] = w_fix;
                if (k_q == 2'd3) begin
                    singular_d    = 1'b0;
                    determinant_d = det_q;
                    for (int i = 0; i < 4; i++) begin
                        inv_d[(4-i)*OW-1 -: OW] = shadow_d[i];
                    end
                end else begin
                    k_d   = w_k_next;
                    cnt_d = '0;
                    rem_d = '0;
                    quo_d = dividend_of(adj_q[w_k_next]);
                end
            end
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                a_q[i]      <= '0;
                adj_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
            det_q         <= '0;
            k_q           <= '0;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            singular_q    <= 1'b0;
            determinant_q <= '0;
            inv_q         <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                a_q[i]      <= a_d[i];
                adj_q[i]    <= adj_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            det_q         <= det_d;
            k_q           <= k_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            singular_q    <= singular_d;
            determinant_q <= determinant_d;
            inv_q         <= inv_d;
        end
    end

    assign singular    = singular_q;
    assign determinant = determinant_q;
    assign inv_mat     = inv_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_2x2_inverse_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_2x2_inverse_seq
//  Brief    : Bench for matrix_2x2_inverse_seq: directed matrices against a
//             cycle-level reference model plus hand-computed results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_matrix_2x2_inverse_seq;

    localparam int W   = 7;
    localparam int F   = 8;
    localparam int OW  = W + F + 1;
    localparam int LAT = 2 + 4*(W+F+1);

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [4*W-1:0]    matA;
    logic              busy;
    logic              done;
    logic              singular;
    logic [2*W:0]      determinant;
    logic [4*OW-1:0]   inv_mat;

    int checks = 0;
    int errors = 0;

    matrix_2x2_inverse_seq #(.WIDTH(W), .FRAC(F)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .matA        (matA),
        .busy        (busy),
        .done        (done),
        .singular    (singular),
        .determinant (determinant),
        .inv_mat     (inv_mat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [4*W-1:0] pk(input int a, input int b, input int c, input int d);
        return {W'(a), W'(b), W'(c), W'(d)};
    endfunction

    function automatic int fld(input int i);
        logic signed [OW-1:0] t;
        t = inv_mat[(4-i)*OW-1 -: OW];
        return int'(t);
    endfunction

    function automatic int det_out();
        logic signed [2*W:0] t;
        t = determinant;
        return int'(t);
    endfunction

    // ---------------- reference model ----------------
    int m_age, m_lat, m_det, x_det;
    int m_inv [4];
    int x_inv [4];
    bit m_sing, x_sing;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_age = 0; m_lat = 0; x_det = 0; x_sing = 0;
            for (int i = 0; i < 4; i++) x_inv[i] = 0;
        end else if (m_age == 0) begin
            if (start) begin
                int a [4];
                int adj [4];
                for (int i = 0; i < 4; i++) begin
                    logic signed [W-1:0] t;
                    t = matA[(4-i)*W-1 -: W];
                    a[i] = int'(t);
                end
                m_det  = a[0]*a[3] - a[1]*a[2];
                adj[0] = a[3]; adj[1] = -a[1]; adj[2] = -a[2]; adj[3] = a[0];
                m_sing = (m_det == 0);
                m_lat  = m_sing ? 2 : LAT;
                for (int i = 0; i < 4; i++)
                    m_inv[i] = m_sing ? 0 : (adj[i] * (1 << F)) / m_det;
                m_age = 1;
            end
        end else if (m_age == m_lat) begin
            m_age = 0;
        end else begin
            m_age++;
            if (m_age == m_lat) begin
                x_det  = m_det;
                x_sing = m_sing;
                for (int i = 0; i < 4; i++) x_inv[i] = m_inv[i];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            bit e_busy, e_done;
            e_done = (m_age != 0) && (m_age == m_lat);
            e_busy = (m_age != 0) && (m_age <  m_lat);
            chk("cyc_done", int'(done), int'(e_done));
            chk("cyc_busy", int'(busy), int'(e_busy));
            chk("cyc_det",  det_out(), x_det);
            for (int i = 0; i < 4; i++) chk($sformatf("cyc_inv%0d", i), fld(i), x_inv[i]);
            if (!e_busy) chk("cyc_singular", int'(singular), int'(x_sing));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_done(input string nm, input int lat, input int edet,
                             input int e0, input int e1, input int e2, input int e3,
                             input int esing);
        int cyc;
        bit got;
        cyc = 0; got = 0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1;
        end
        chk({nm, "_latency"}, got ? cyc : -1, lat);
        if (got) begin
            chk({nm, "_det"},  det_out(), edet);
            chk({nm, "_i00"},  fld(0), e0);
            chk({nm, "_i01"},  fld(1), e1);
            chk({nm, "_i10"},  fld(2), e2);
            chk({nm, "_i11"},  fld(3), e3);
            chk({nm, "_sing"}, int'(singular), esing);
        end
    endtask

    task automatic run_op(input string nm, input int a00, input int a01, input int a10, input int a11,
                          input int lat, input int edet,
                          input int e0, input int e1, input int e2, input int e3, input int esing);
        @(posedge clk); #1;
        matA  = pk(a00, a01, a10, a11);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(nm, lat, edet, e0, e1, e2, e3, esing);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_sing"}, int'(singular), 0);
        chk({nm, "_det"},  det_out(), 0);
        for (int i = 0; i < 4; i++) chk($sformatf("%s_inv%0d", nm, i), fld(i), 0);
    endtask

    initial begin
        int cyc;
        bit got;
        reset_n = 1'b0;
        start   = 1'b0;
        matA    = '0;
        #3;
        chk_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;

        run_op("diag",    2,  0,  0,  4, 66,     8,  128,    0,    0,   64, 0);
        run_op("mixed",   1,  2,  3,  4, 66,    -2, -512,  256,  384, -128, 0);
        run_op("sing",    2,  4,  1,  2,  2,     0,    0,    0,    0,    0, 1);
        run_op("trunc",   3,  0,  0,  3, 66,     9,   85,    0,    0,   85, 0);
        run_op("negdet", -3,  0,  0,  3, 66,    -9,  -85,    0,    0,   85, 0);
        run_op("extreme",-64, 0,  0,  1, 66,   -64,   -4,    0,    0,  256, 0);
        run_op("zeroq",   1,-64,-64,  1, 66, -4095,    0,   -4,   -4,    0, 0);
        run_op("near",  -64, 63, 63,-64, 66,   127, -129, -126, -126, -129, 0);

        // Protocol: starts while busy and in the DONE cycle are ignored.
        @(posedge clk); #1;
        matA  = pk(1, 2, 3, 4);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; got = 0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 10) begin matA = pk(2, 0, 0, 4); start = 1'b1; end
            if (cyc == 11) start = 1'b0;
            if (done) got = 1;
        end
        start = 1'b1;
        chk("proto_latency", got ? cyc : -1, 66);
        chk("proto_det", det_out(), -2);
        chk("proto_i00", fld(0), -512);
        chk("proto_i11", fld(3), -128);
        @(negedge clk);
        chk("proto_idle_busy", int'(busy), 0);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("proto2", 66, 8, 128, 0, 0, 64, 0);

        // Reset in the middle of an operation.
        @(posedge clk); #1;
        matA  = pk(1, 2, 3, 4);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(negedge clk);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (3) begin
            @(negedge clk);
            chk("midreset_nodone", int'(done), 0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        run_op("after_rst", 2, 0, 0, 4, 66, 8, 128, 0, 0, 64, 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
